angle_sweep_gen: RTL and testbench
==================================

ANGLE_SWEEP_GEN -- requirements
Module: angle_sweep_gen

Interface
REQ-001 SHALL have parameter INT_W, default 10, integer bits of the angle word.
REQ-002 SHALL have parameter FRAC_W, default 45, fraction bits of the angle word (1..45).
REQ-003 SHALL have parameter COEF_W, default 19, fraction bits of the coefficient.
REQ-004 SHALL have parameter NPT_W, default 9, width of the points-per-step count.
REQ-005 SHALL have parameter NSTEP_W, default 12, width of the step count.
REQ-006 SHALL have ports: clk in 1, system clock; rst in 1, reset (one clock; reset is synchronous and active-high).
REQ-007 SHALL have ports: coef in COEF_W, unsigned fractional coefficient; coef_valid in 1, coefficient load strobe.
REQ-008 SHALL have ports: start in 1, sweep start pulse; num_points in NPT_W, angles per step; num_steps in NSTEP_W, steps per sweep; theta_step in W, per-step angle increment (W=1+INT_W+FRAC_W, two's complement).
REQ-009 SHALL have ports: step_done in 1, downstream end-of-step pulse; angle_ready in 1, consumer ready.
REQ-010 SHALL have ports: angle_out out W, wrapped angle; angle_valid out 1; busy out 1; sweep_done out 1, pulse; step_idx out NSTEP_W; overrun out 1, sticky error.

Function
REQ-011 SHALL latch delta = floor(coef*PI / 2^COEF_W) one cycle after coef_valid; a new delta SHALL take effect only at the next start.
REQ-012 SHALL implement states IDLE, GEN, WAIT; IDLE->GEN on start; GEN->WAIT after the last angle of a step is accepted; WAIT->GEN on step_done if step_idx < num_steps-1, else WAIT->IDLE with sweep_done pulsed one cycle.
REQ-013 SHALL latch num_points, num_steps, theta_step on start; step_idx SHALL reset to 0 on start and increment on each accepted step_done.
REQ-014 SHALL keep theta_k = k*theta_step and the point accumulator acc in signed [-PI, PI); any add yielding >= PI SHALL subtract TWO_PI, < -PI SHALL add TWO_PI (single correction; |theta_step| < TWO_PI, delta < PI guaranteed).
REQ-015 SHALL emit, per step k, angles acc_n = wrap(theta_k + n*delta) for n = 1..num_points, in order.
REQ-016 SHALL present angle_out/angle_valid from a register; while angle_valid=1 and angle_ready=0, angle_out SHALL hold and no new angle is computed.
REQ-017 SHALL assert the first angle_valid two cycles after start (start sampled cycle t, valid at t+2) when angle_ready is held high, then one angle per cycle.
REQ-018 SHALL treat num_points=0 as GEN->WAIT immediately with no output; num_steps=0 SHALL go IDLE with sweep_done one cycle after start.
REQ-019 SHALL set overrun when step_done arrives in GEN or IDLE, ignore that pulse, and clear overrun only on start or rst.
REQ-020 SHALL on start while busy abort the current sweep, drop any pending angle_valid, and restart from step 0 without sweep_done.
REQ-021 SHALL drive busy=1 in GEN and WAIT.

Reset
REQ-022 SHALL on rst set state IDLE, angle_out 0, angle_valid 0, busy 0, sweep_done 0, step_idx 0, overrun 0, delta 0, acc and theta_k 0; rst overrides start, coef_valid, step_done in the same cycle.

Structure
REQ-023 SHALL take PI (45 fraction bits, even LSB), TWO_PI = PI<<1, and the state enum from package angle_sweep_pkg; constants SHALL be right-shifted by 45-FRAC_W.
REQ-024 SHALL isolate the conditional-wrap adder as sub-module phase_wrap_add (a, b -> wrapped sum), instantiated for theta and point accumulation.

Verification
REQ-025 coef=0, theta_step=0, num_points=3, num_steps=2, ready=1 -> six angles all 0, sweep_done after second step_done.
REQ-026 coef=0x40000 (0.5), theta_step=0, num_points=4 -> angles PI/2, -PI, -PI/2, 0 exactly.
REQ-027 coef=0, theta_step=PI/2, num_points=1, num_steps=5 -> angles PI/2, -PI, -PI/2, 0, PI/2; step_idx 0..4.
REQ-028 angle_ready low 3 cycles mid-step -> angle_out stable, no angle lost or duplicated.
REQ-029 step_done during GEN -> overrun=1, pulse ignored; start mid-sweep -> restart at step 0, overrun cleared, no sweep_done.
REQ-030 num_steps=0 -> sweep_done at start+1, angle_valid never asserted; rst mid-GEN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/angle_sweep_pkg.sv
// Shared constants and state type for the angle sweep generator.
//   PI_Q45     : PI with 45 fraction bits, LSB forced even so PI/2 is exact
//   TWO_PI_Q45 : PI_Q45 shifted left by one
//   PI_FRAC    : fraction width the Q45 constants are expressed in
//   state_t    : sweep controller states
// Users narrow the constants with a right shift of (PI_FRAC - FRAC_W).
package angle_sweep_pkg;

    localparam int          PI_FRAC    = 45;
    localparam logic [46:0] PI_Q45     = 47'h6487ED5110B4;
    localparam logic [47:0] TWO_PI_Q45 = {PI_Q45, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/angle_sweep_gen_if.sv
// Bundle of all configuration, handshake and status signals of the sweep
// generator. The master side (controller / consumer) drives configuration,
// start, step_done and angle_ready; the slave side (the generator) drives
// angle_out/angle_valid and the status flags busy, sweep_done, step_idx and
// overrun.
interface angle_sweep_gen_if #(
    parameter int INT_W   = 10,
    parameter int FRAC_W  = 45,
    parameter int COEF_W  = 19,
    parameter int NPT_W   = 9,
    parameter int NSTEP_W = 12
);

    localparam int W = 1 + INT_W + FRAC_W;

    logic [COEF_W-1:0]   coef;
    logic                coef_valid;
    logic                start;
    logic [NPT_W-1:0]    num_points;
    logic [NSTEP_W-1:0]  num_steps;
    logic signed [W-1:0] theta_step;
    logic                step_done;
    logic                angle_ready;
    logic signed [W-1:0] angle_out;
    logic                angle_valid;
    logic                busy;
    logic                sweep_done;
    logic [NSTEP_W-1:0]  step_idx;
    logic                overrun;

    modport master (
        output coef, coef_valid, start, num_points, num_steps, theta_step,
               step_done, angle_ready,
        input  angle_out, angle_valid, busy, sweep_done, step_idx, overrun
    );

    modport slave (
        input  coef, coef_valid, start, num_points, num_steps, theta_step,
               step_done, angle_ready,
        output angle_out, angle_valid, busy, sweep_done, step_idx, overrun
    );

endinterface

// File: rtl/phase_wrap_add.sv
// Combinational adder that keeps a phase inside [-PI, PI).
//   i_a   : current phase, already inside [-PI, PI)
//   i_b   : increment, magnitude below TWO_PI
//   o_sum : i_a + i_b folded back into [-PI, PI) with one correction
module phase_wrap_add
    import angle_sweep_pkg::*;
#(
    parameter int FRAC_W = 45,
    parameter int W      = 56
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum
);

    // Two guard bits so the raw sum (range about +/-3*PI) never overflows.
    localparam logic signed [W+1:0] PI_X     = (W+2)'(PI_Q45 >> (PI_FRAC - FRAC_W));
    localparam logic signed [W+1:0] TWO_PI_X = (W+2)'(TWO_PI_Q45 >> (PI_FRAC - FRAC_W));
    localparam logic signed [W+1:0] NEG_PI_X = -PI_X;

    logic signed [W+1:0] w_raw;
    logic signed [W+1:0] w_fix;

    assign w_raw = {{2{i_a[W-1]}}, i_a} + {{2{i_b[W-1]}}, i_b};

    // A single add or subtract of TWO_PI is enough because both operands
    // are bounded, so no iteration is needed.
    always_comb begin
        w_fix = w_raw;
        if (w_raw >= PI_X) begin
            w_fix = w_raw - TWO_PI_X;
        end else if (w_raw < NEG_PI_X) begin
            w_fix = w_raw + TWO_PI_X;
        end
    end

    assign o_sum = W'(w_fix);

endmodule

// File: rtl/angle_sweep_gen.sv
// Angle sweep generator. For each step k (k = 1..num_steps) it emits
// num_points wrapped angles theta_k + n*delta (n = 1..num_points), with
// theta_k = k*theta_step and delta = floor(coef*PI / 2^COEF_W). Between
// steps it waits for a downstream step_done pulse.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of angle_sweep_gen_if (config, handshakes, status)
module angle_sweep_gen
    import angle_sweep_pkg::*;
#(
    parameter int INT_W   = 10,
    parameter int FRAC_W  = 45,
    parameter int COEF_W  = 19,
    parameter int NPT_W   = 9,
    parameter int NSTEP_W = 12
) (
    input logic              clk,
    input logic              rst,
    angle_sweep_gen_if.slave bus
);

    localparam int          W    = 1 + INT_W + FRAC_W;
    localparam logic [W-1:0] PI_W = W'(PI_Q45 >> (PI_FRAC - FRAC_W));

    state_t              r_state;
    logic signed [W-1:0] r_delta;
    logic signed [W-1:0] r_deltaAct;
    logic signed [W-1:0] r_thetaStep;
    logic signed [W-1:0] r_theta;
    logic signed [W-1:0] r_acc;
    logic [NPT_W-1:0]    r_numPoints;
    logic [NSTEP_W-1:0]  r_numSteps;
    logic [NPT_W-1:0]    r_cnt;
    logic                r_init;
    logic signed [W-1:0] r_angleOut;
    logic                r_angleValid;
    logic                r_busy;
    logic                r_sweepDone;
    logic [NSTEP_W-1:0]  r_stepIdx;
    logic                r_overrun;

    logic [COEF_W+W-1:0] w_prod;
    logic signed [W-1:0] w_nextTheta;
    logic signed [W-1:0] w_nextAcc;
    logic                w_outFree;
    logic                w_moreSteps;

    assign w_prod      = (COEF_W+W)'(bus.coef) * (COEF_W+W)'(PI_W);
    assign w_outFree   = !r_angleValid || bus.angle_ready;
    assign w_moreSteps = ({1'b0, r_stepIdx} + (NSTEP_W+1)'(1)) < {1'b0, r_numSteps};

    phase_wrap_add #(.FRAC_W(FRAC_W), .W(W)) u_thetaAdd (
        .i_a   (r_theta),
        .i_b   (r_thetaStep),
        .o_sum (w_nextTheta)
    );

    phase_wrap_add #(.FRAC_W(FRAC_W), .W(W)) u_accAdd (
        .i_a   (r_acc),
        .i_b   (r_deltaAct),
        .o_sum (w_nextAcc)
    );

    // Sweep controller. The staged delta (r_delta) follows coef_valid at any
    // time, but only start copies it into the working delta, so a sweep in
    // flight is never disturbed by a coefficient reload. Every step begins
    // with one init cycle that advances theta and seeds the point
    // accumulator with it, so step s runs at (s+1)*theta_step and the first
    // angle of a sweep appears two cycles after start. A start while busy
    // takes the same path as a start from idle, which is what aborts the
    // current sweep and drops any pending angle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_delta      <= '0;
            r_deltaAct   <= '0;
            r_thetaStep  <= '0;
            r_theta      <= '0;
            r_acc        <= '0;
            r_numPoints  <= '0;
            r_numSteps   <= '0;
            r_cnt        <= '0;
            r_init       <= 1'b0;
            r_angleOut   <= '0;
            r_angleValid <= 1'b0;
            r_busy       <= 1'b0;
            r_sweepDone  <= 1'b0;
            r_stepIdx    <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_sweepDone <= 1'b0;
            if (bus.coef_valid) begin
                r_delta <= W'(w_prod >> COEF_W);
            end
            if (bus.start) begin
                r_numPoints  <= bus.num_points;
                r_numSteps   <= bus.num_steps;
                r_thetaStep  <= bus.theta_step;
                r_deltaAct   <= r_delta;
                r_theta      <= '0;
                r_acc        <= '0;
                r_cnt        <= '0;
                r_stepIdx    <= '0;
                r_overrun    <= 1'b0;
                r_angleValid <= 1'b0;
                r_init       <= 1'b1;
                if (bus.num_steps == '0) begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_sweepDone <= 1'b1;
                end else begin
                    r_state <= ST_GEN;
                    r_busy  <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.step_done) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    ST_GEN: begin
                        if (bus.step_done) begin
                            r_overrun <= 1'b1;
                        end
                        if (r_init) begin
                            r_theta <= w_nextTheta;
                            r_acc   <= w_nextTheta;
                            r_cnt   <= '0;
                            r_init  <= 1'b0;
                        end else if (w_outFree) begin
                            if (r_cnt < r_numPoints) begin
                                r_angleOut   <= w_nextAcc;
                                r_acc        <= w_nextAcc;
                                r_angleValid <= 1'b1;
                                r_cnt        <= r_cnt + NPT_W'(1);
                            end else begin
                                r_angleValid <= 1'b0;
                                r_state      <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (bus.step_done) begin
                            r_stepIdx <= r_stepIdx + NSTEP_W'(1);
                            if (w_moreSteps) begin
                                r_init  <= 1'b1;
                                r_state <= ST_GEN;
                            end else begin
                                r_state     <= ST_IDLE;
                                r_busy      <= 1'b0;
                                r_sweepDone <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.angle_out   = r_angleOut;
    assign bus.angle_valid = r_angleValid;
    assign bus.busy        = r_busy;
    assign bus.sweep_done  = r_sweepDone;
    assign bus.step_idx    = r_stepIdx;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_angle_sweep_gen.sv
// Self-checking bench for angle_sweep_gen. Expected angles come from a
// plain modular-arithmetic model: angle = ((s+1)*theta_step + n*delta)
// reduced into [-PI, PI).
module tb_angle_sweep_gen;

    localparam int INT_W   = 10;
    localparam int FRAC_W  = 45;
    localparam int COEF_W  = 19;
    localparam int NPT_W   = 9;
    localparam int NSTEP_W = 12;
    localparam int W       = 1 + INT_W + FRAC_W;

    localparam longint PI_REF     = 64'h6487ED5110B4;
    localparam longint TWO_PI_REF = 2 * PI_REF;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    logic signed [W-1:0] gotQ[$];

    angle_sweep_gen_if #(
        .INT_W(INT_W), .FRAC_W(FRAC_W), .COEF_W(COEF_W),
        .NPT_W(NPT_W), .NSTEP_W(NSTEP_W)
    ) sb ();

    angle_sweep_gen #(
        .INT_W(INT_W), .FRAC_W(FRAC_W), .COEF_W(COEF_W),
        .NPT_W(NPT_W), .NSTEP_W(NSTEP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    always #5 clk = ~clk;

    // Reference model: delta straight from its definition, angle from the
    // true sum reduced modulo TWO_PI.
    function automatic longint refDelta(input int unsigned c);
        logic [127:0] p;
        p = 128'(c) * 128'(PI_REF);
        return longint'(p >> COEF_W);
    endfunction

    function automatic logic signed [W-1:0] refAngle(input int s, input int n,
                                                     input longint ts, input longint d);
        longint x;
        longint m;
        x = longint'(s + 1) * ts + longint'(n) * d;
        m = (x + PI_REF) % TWO_PI_REF;
        if (m < 0) m = m + TWO_PI_REF;
        return W'(m - PI_REF);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus;
        sb.coef        = '0;
        sb.coef_valid  = 1'b0;
        sb.start       = 1'b0;
        sb.num_points  = '0;
        sb.num_steps   = '0;
        sb.theta_step  = '0;
        sb.step_done   = 1'b0;
        sb.angle_ready = 1'b0;
    endtask

    task automatic loadCoef(input int unsigned c);
        sb.coef       = COEF_W'(c);
        sb.coef_valid = 1'b1;
        tick();
        sb.coef_valid = 1'b0;
        tick();
    endtask

    task automatic startSweep(input int npts, input int nsteps, input longint ts);
        sb.num_points = NPT_W'(npts);
        sb.num_steps  = NSTEP_W'(nsteps);
        sb.theta_step = W'(ts);
        sb.start      = 1'b1;
        tick();
        sb.start      = 1'b0;
    endtask

    task automatic pulseStepDone;
        sb.step_done = 1'b1;
        tick();
        sb.step_done = 1'b0;
    endtask

    // Collects n accepted angles into gotQ; leaves angle_ready low on exit.
    task automatic drain(input int n, input bit rnd, output bit timedOut);
        int got = 0;
        int budget = 0;
        timedOut = 1'b0;
        while (got < n) begin
            sb.angle_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sb.angle_valid && sb.angle_ready) begin
                gotQ.push_back(sb.angle_out);
                got++;
            end
            tick();
            budget++;
            if (budget > 400) begin
                timedOut = 1'b1;
                break;
            end
        end
        sb.angle_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sb.start = 1'b1; sb.coef_valid = 1'b1; sb.step_done = 1'b1; sb.angle_ready = 1'b1;
        sb.num_steps = NSTEP_W'(2); sb.num_points = NPT_W'(2);
        tick();
        tick();
        total++; if (sb.angle_out !== '0)   begin bad++; $display("[TB] FAIL reset angle_out got=%h exp=0", sb.angle_out); end
        total++; if (sb.angle_valid !== 0)  begin bad++; $display("[TB] FAIL reset angle_valid got=%b exp=0", sb.angle_valid); end
        total++; if (sb.busy !== 0)         begin bad++; $display("[TB] FAIL reset busy got=%b exp=0", sb.busy); end
        total++; if (sb.sweep_done !== 0)   begin bad++; $display("[TB] FAIL reset sweep_done got=%b exp=0", sb.sweep_done); end
        total++; if (sb.step_idx !== '0)    begin bad++; $display("[TB] FAIL reset step_idx got=%0d exp=0", sb.step_idx); end
        total++; if (sb.overrun !== 0)      begin bad++; $display("[TB] FAIL reset overrun got=%b exp=0", sb.overrun); end
        applyStimulus();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sweep_case(input string tag, input int unsigned c, input longint ts,
                                   input int npts, input int nsteps, input bit rnd);
        longint d;
        bit to;
        d = refDelta(c);
        loadCoef(c);
        sb.angle_ready = 1'b0;
        startSweep(npts, nsteps, ts);
        tick();
        total++; if (sb.angle_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s latency t+1 valid got=%b exp=0", tag, sb.angle_valid); end
        tick();
        total++; if (sb.angle_valid !== (npts > 0)) begin bad++; $display("[TB] FAIL %s latency t+2 valid got=%b exp=%b", tag, sb.angle_valid, (npts > 0)); end
        for (int s = 0; s < nsteps; s++) begin
            gotQ.delete();
            drain(npts, rnd, to);
            total++; if (to) begin bad++; $display("[TB] FAIL %s step %0d drain got=%0d angles exp=%0d", tag, s, gotQ.size(), npts); end
            for (int n = 0; n < gotQ.size(); n++) begin
                total++;
                if (gotQ[n] !== refAngle(s, n + 1, ts, d)) begin
                    bad++;
                    $display("[TB] FAIL %s angle s=%0d n=%0d got=%h exp=%h", tag, s, n + 1, gotQ[n], refAngle(s, n + 1, ts, d));
                end
            end
            sb.angle_ready = 1'b1;
            tick();
            tick();
            sb.angle_ready = 1'b0;
            total++; if (sb.angle_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s extra angle step %0d valid got=%b exp=0", tag, s, sb.angle_valid); end
            total++; if (sb.step_idx !== NSTEP_W'(s)) begin bad++; $display("[TB] FAIL %s step_idx got=%0d exp=%0d", tag, sb.step_idx, s); end
            total++; if (sb.busy !== 1'b1) begin bad++; $display("[TB] FAIL %s busy in step got=%b exp=1", tag, sb.busy); end
            pulseStepDone();
            if (s < nsteps - 1) begin
                total++; if (sb.step_idx !== NSTEP_W'(s + 1)) begin bad++; $display("[TB] FAIL %s step_idx advance got=%0d exp=%0d", tag, sb.step_idx, s + 1); end
                tick();
                tick();
            end else begin
                total++; if (sb.sweep_done !== 1'b1) begin bad++; $display("[TB] FAIL %s sweep_done got=%b exp=1", tag, sb.sweep_done); end
                total++; if (sb.busy !== 1'b0) begin bad++; $display("[TB] FAIL %s busy after sweep got=%b exp=0", tag, sb.busy); end
                tick();
                total++; if (sb.sweep_done !== 1'b0) begin bad++; $display("[TB] FAIL %s sweep_done pulse width got=%b exp=0", tag, sb.sweep_done); end
            end
        end
    endtask

    task automatic test_backpressure;
        int unsigned c;
        longint ts;
        longint d;
        logic signed [W-1:0] hold;
        bit to;
        c  = $urandom_range(1, (1 << COEF_W) - 1);
        ts = longint'($urandom_range(0, 65535)) * 32768;
        d  = refDelta(c);
        loadCoef(c);
        startSweep(8, 1, ts);
        tick();
        tick();
        gotQ.delete();
        drain(3, 1'b0, to);
        hold = sb.angle_out;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (sb.angle_valid !== 1'b1 || sb.angle_out !== hold) begin
                bad++;
                $display("[TB] FAIL stall hold cycle %0d got=%h/%b exp=%h/1", i, sb.angle_out, sb.angle_valid, hold);
            end
        end
        drain(5, 1'b0, to);
        total++; if (to || gotQ.size() != 8) begin bad++; $display("[TB] FAIL stall count got=%0d exp=8", gotQ.size()); end
        for (int n = 0; n < gotQ.size(); n++) begin
            total++;
            if (gotQ[n] !== refAngle(0, n + 1, ts, d)) begin
                bad++;
                $display("[TB] FAIL stall angle n=%0d got=%h exp=%h", n + 1, gotQ[n], refAngle(0, n + 1, ts, d));
            end
        end
        tick();
        tick();
        pulseStepDone();
        total++; if (sb.sweep_done !== 1'b1) begin bad++; $display("[TB] FAIL stall sweep_done got=%b exp=1", sb.sweep_done); end
        tick();
    endtask

    task automatic test_overrun_restart;
        int unsigned c;
        longint ts;
        longint ts2;
        longint d;
        bit to;
        c   = $urandom_range(1, (1 << COEF_W) - 1);
        ts  = longint'($urandom_range(0, 65535)) * 32768;
        ts2 = -(longint'($urandom_range(0, 65535)) * 32768);
        d   = refDelta(c);
        loadCoef(c);
        startSweep(6, 3, ts);
        tick();
        tick();
        gotQ.delete();
        drain(2, 1'b0, to);
        pulseStepDone();
        total++; if (sb.overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun set got=%b exp=1", sb.overrun); end
        total++; if (sb.step_idx !== '0) begin bad++; $display("[TB] FAIL overrun ignored step_idx got=%0d exp=0", sb.step_idx); end
        drain(4, 1'b0, to);
        total++; if (to || gotQ.size() != 6) begin bad++; $display("[TB] FAIL overrun step count got=%0d exp=6", gotQ.size()); end
        for (int n = 0; n < gotQ.size(); n++) begin
            total++;
            if (gotQ[n] !== refAngle(0, n + 1, ts, d)) begin
                bad++;
                $display("[TB] FAIL overrun angle n=%0d got=%h exp=%h", n + 1, gotQ[n], refAngle(0, n + 1, ts, d));
            end
        end
        tick();
        tick();
        pulseStepDone();
        total++; if (sb.step_idx !== NSTEP_W'(1) || sb.overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun sticky idx=%0d ovr=%b exp idx=1 ovr=1", sb.step_idx, sb.overrun); end
        tick();
        tick();
        gotQ.delete();
        drain(2, 1'b0, to);
        for (int n = 0; n < gotQ.size(); n++) begin
            total++;
            if (gotQ[n] !== refAngle(1, n + 1, ts, d)) begin
                bad++;
                $display("[TB] FAIL step1 angle n=%0d got=%h exp=%h", n + 1, gotQ[n], refAngle(1, n + 1, ts, d));
            end
        end
        startSweep(2, 1, ts2);
        total++;
        if (sb.overrun !== 1'b0 || sb.sweep_done !== 1'b0 || sb.angle_valid !== 1'b0 ||
            sb.step_idx !== '0 || sb.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL restart ovr=%b done=%b valid=%b idx=%0d busy=%b exp 0 0 0 0 1",
                     sb.overrun, sb.sweep_done, sb.angle_valid, sb.step_idx, sb.busy);
        end
        tick();
        tick();
        gotQ.delete();
        drain(2, 1'b0, to);
        total++; if (to || gotQ.size() != 2) begin bad++; $display("[TB] FAIL restart count got=%0d exp=2", gotQ.size()); end
        for (int n = 0; n < gotQ.size(); n++) begin
            total++;
            if (gotQ[n] !== refAngle(0, n + 1, ts2, d)) begin
                bad++;
                $display("[TB] FAIL restart angle n=%0d got=%h exp=%h", n + 1, gotQ[n], refAngle(0, n + 1, ts2, d));
            end
        end
        tick();
        tick();
        pulseStepDone();
        total++; if (sb.sweep_done !== 1'b1) begin bad++; $display("[TB] FAIL restart sweep_done got=%b exp=1", sb.sweep_done); end
        tick();
    endtask

    task automatic test_coef_latch;
        int unsigned cA;
        int unsigned cB;
        longint dA;
        longint dB;
        bit to;
        cA = $urandom_range(1, 200000);
        cB = cA + $urandom_range(1, 300000);
        dA = refDelta(cA);
        dB = refDelta(cB);
        loadCoef(cA);
        startSweep(4, 1, 0);
        tick();
        tick();
        gotQ.delete();
        drain(2, 1'b0, to);
        loadCoef(cB);
        drain(2, 1'b0, to);
        for (int n = 0; n < gotQ.size(); n++) begin
            total++;
            if (gotQ[n] !== refAngle(0, n + 1, 0, dA)) begin
                bad++;
                $display("[TB] FAIL coef latch old n=%0d got=%h exp=%h", n + 1, gotQ[n], refAngle(0, n + 1, 0, dA));
            end
        end
        tick();
        tick();
        pulseStepDone();
        tick();
        startSweep(2, 1, 0);
        tick();
        tick();
        gotQ.delete();
        drain(2, 1'b0, to);
        total++; if (to || gotQ.size() != 2) begin bad++; $display("[TB] FAIL coef latch count got=%0d exp=2", gotQ.size()); end
        for (int n = 0; n < gotQ.size(); n++) begin
            total++;
            if (gotQ[n] !== refAngle(0, n + 1, 0, dB)) begin
                bad++;
                $display("[TB] FAIL coef latch new n=%0d got=%h exp=%h", n + 1, gotQ[n], refAngle(0, n + 1, 0, dB));
            end
        end
        tick();
        tick();
        pulseStepDone();
        tick();
    endtask

    task automatic test_zero_steps;
        bit seen;
        startSweep(3, 0, 0);
        total++;
        if (sb.sweep_done !== 1'b1 || sb.busy !== 1'b0 || sb.angle_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero steps done=%b busy=%b valid=%b exp 1 0 0", sb.sweep_done, sb.busy, sb.angle_valid);
        end
        seen = 1'b0;
        sb.angle_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sb.angle_valid !== 1'b0 || sb.sweep_done !== 1'b0 || sb.busy !== 1'b0) seen = 1'b1;
        end
        sb.angle_ready = 1'b0;
        total++; if (seen) begin bad++; $display("[TB] FAIL zero steps activity after start got=1 exp=0"); end
    endtask

    task automatic test_reset_mid;
        bit to;
        loadCoef(32'h12345);
        startSweep(5, 2, longint'($urandom_range(1, 65535)) * 32768);
        tick();
        tick();
        gotQ.delete();
        drain(2, 1'b0, to);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (sb.angle_out !== '0)  begin bad++; $display("[TB] FAIL midrst angle_out got=%h exp=0", sb.angle_out); end
        total++; if (sb.angle_valid !== 0) begin bad++; $display("[TB] FAIL midrst angle_valid got=%b exp=0", sb.angle_valid); end
        total++; if (sb.busy !== 0)        begin bad++; $display("[TB] FAIL midrst busy got=%b exp=0", sb.busy); end
        total++; if (sb.step_idx !== '0 || sb.overrun !== 0 || sb.sweep_done !== 0) begin
            bad++; $display("[TB] FAIL midrst status idx=%0d ovr=%b done=%b exp 0 0 0", sb.step_idx, sb.overrun, sb.sweep_done);
        end
        startSweep(3, 1, 0);
        tick();
        tick();
        gotQ.delete();
        drain(3, 1'b0, to);
        total++; if (to || gotQ.size() != 3) begin bad++; $display("[TB] FAIL midrst count got=%0d exp=3", gotQ.size()); end
        for (int n = 0; n < gotQ.size(); n++) begin
            total++;
            if (gotQ[n] !== refAngle(0, n + 1, 0, 0)) begin
                bad++;
                $display("[TB] FAIL midrst delta cleared n=%0d got=%h exp=%h", n + 1, gotQ[n], refAngle(0, n + 1, 0, 0));
            end
        end
        tick();
        tick();
        pulseStepDone();
        tick();
    endtask

    task automatic test_random;
        int unsigned c;
        longint ts;
        for (int i = 0; i < 4; i++) begin
            c  = $urandom_range(0, (1 << COEF_W) - 1);
            ts = longint'($urandom) * 32768 + longint'($urandom_range(0, 32767));
            if ($urandom_range(0, 1) == 1) ts = -ts;
            test_sweep_case("random", c, ts, $urandom_range(1, 6), $urandom_range(1, 4), 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        applyStimulus();
        test_reset();
        test_sweep_case("zero", 0, 0, 3, 2, 1'b0);
        test_sweep_case("half", 32'h40000, 0, 4, 1, 1'b0);
        test_sweep_case("quarter", 0, PI_REF / 2, 1, 5, 1'b0);
        test_sweep_case("nopoints", 32'h1000, PI_REF / 4, 0, 2, 1'b0);
        test_backpressure();
        test_overrun_restart();
        test_coef_latch();
        test_zero_steps();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
